// File: rtl/aes_ser_pkg.sv
// aes_ser_pkg: shared states, block size and width helpers for the AES serial port
package aes_ser_pkg;
  typedef enum logic [2:0] {IDLE, RX_DATA, RX_KEY, RX_PAR, START, WAIT, TX, DONE} state_e;
  localparam int BLK_BITS = 128;
  function automatic int key_bits(input int nk);
    return 32 * nk;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/aes_ser_shreg.sv
// aes_ser_shreg: indexed bit capture/emit register with bit counter, next-bit and last-bit flag
module aes_ser_shreg
  import aes_ser_pkg::*;
#(
  parameter int W  = 128,
  parameter int CW = cnt_w(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         step,
  input  logic         wr,
  input  logic         ld,
  input  logic         din,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic         nxt,
  output logic         last
);
  logic [W-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    q_d = ld ? ld_val : q_q;
    if (step && wr) q_d[cnt_q] = din;
    cnt_d = (clr || ld) ? '0 : step ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end
  assign q    = q_q;
  assign nxt  = q_d[cnt_d];
  assign last = cnt_q == CW'(W - 1);
endmodule

// File: rtl/aes_serial_port.sv
// aes_serial_port: bit-serial responder feeding an AES core (cs/miso in, mosi/finished out); parity check via AES_SER_PARITY_EN
module aes_serial_port
  import aes_ser_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nb = 4,
  parameter int Nr = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     miso,
  output logic                     mosi,
  output logic                     finished,
  output logic                     err,
  output logic                     busy,
  output logic                     core_start,
  output logic [BLK_BITS-1:0]      core_data,
  output logic [key_bits(Nk)-1:0]  core_key,
  input  logic                     core_done,
  input  logic [BLK_BITS-1:0]      core_result
);
  localparam int KB = key_bits(Nk);
  state_e state_q, state_d;
  logic mosi_q, mosi_d, fin_q, fin_d, err_q, err_d, busy_q, busy_d, st_q, st_d;
  logic d_last, k_last, r_last, r_nxt, par_bad, clr, d_step, k_step, r_ld, r_step;
  logic unused_d_nxt, unused_k_nxt;
  logic [BLK_BITS-1:0] unused_res;
`ifdef AES_SER_PARITY_EN
  localparam state_e KEY_NEXT = RX_PAR;
  assign par_bad = (^core_data) ^ (^core_key) ^ miso;
`else
  localparam state_e KEY_NEXT = START;
  assign par_bad = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cs ? RX_DATA : IDLE;
      RX_DATA: state_d = !cs ? IDLE : d_last ? RX_KEY : RX_DATA;
      RX_KEY:  state_d = !cs ? IDLE : k_last ? KEY_NEXT : RX_KEY;
      RX_PAR:  state_d = !cs ? IDLE : par_bad ? DONE : START;
      START:   state_d = cs ? WAIT : IDLE;
      WAIT:    state_d = !cs ? IDLE : core_done ? TX : WAIT;
      TX:      state_d = !cs ? IDLE : r_last ? DONE : TX;
      DONE:    state_d = cs ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    d_step = cs && (state_q == IDLE || state_q == RX_DATA);
    k_step = cs && state_q == RX_KEY;
    r_ld   = cs && state_q == WAIT && core_done;
    r_step = cs && state_q == TX;
    clr    = state_d == IDLE;
    busy_d = state_d != IDLE;
    st_d   = state_d == START;
    fin_d  = state_d == DONE && state_q != DONE;
    err_d  = fin_d && state_q == RX_PAR;
    mosi_d = (r_ld || (r_step && !r_last)) && r_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mosi_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mosi_q  <= mosi_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      st_q    <= st_d;
    end
  end
  aes_ser_shreg #(.W(BLK_BITS)) u_data (
    .clk(clk), .rst(rst), .clr(clr), .step(d_step), .wr(1'b1), .ld(1'b0), .din(miso),
    .ld_val('0), .q(core_data), .nxt(unused_d_nxt), .last(d_last)
  );
  aes_ser_shreg #(.W(KB)) u_key (
    .clk(clk), .rst(rst), .clr(clr), .step(k_step), .wr(1'b1), .ld(1'b0), .din(miso),
    .ld_val('0), .q(core_key), .nxt(unused_k_nxt), .last(k_last)
  );
  aes_ser_shreg #(.W(BLK_BITS)) u_res (
    .clk(clk), .rst(rst), .clr(clr), .step(r_step), .wr(1'b0), .ld(r_ld), .din(1'b0),
    .ld_val(core_result), .q(unused_res), .nxt(r_nxt), .last(r_last)
  );
  assign mosi       = mosi_q;
  assign finished   = fin_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign core_start = st_q;
endmodule

// File: doc/aes_serial_port.md
Name: aes_serial_port

Overview:
- Device-side serial front-end for the Encrypt/Decrypt cores. It is the responder end of the host's cs/miso/mosi/finished bit-serial link.
- Deserializes a 128-bit block plus a 32*Nk-bit key from miso and launches the core through a start/done handshake. It then serializes the 128-bit result onto mosi and pulses finished.
- Link naming is fixed: miso = serial into device, mosi = serial out of device.
- One instance per core: Encrypt and Decrypt each get their own port.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8); KEY_BITS = 32*Nk.
- Nb, 4, block length in 32-bit words; BLK_BITS = 32*Nb (128).
- Nr, 10, round count; passed through only, unused internally.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  transaction enable from host; high = transaction active.
- miso  in  1  serial data/key bits from host, sampled on posedge while cs=1.
- mosi  out  1  serial result bits to host, registered.
- finished  out  1  one-cycle pulse when the transaction completes.
- err  out  1  qualifies finished; always 0 unless the optional feature is compiled in.
- busy  out  1  high in any state other than IDLE.
- core_start  out  1  one-cycle pulse launching the core.
- core_data  out  BLK_BITS  deserialized block, held stable from core_start until IDLE.
- core_key  out  KEY_BITS  deserialized key, same hold rule as core_data.
- core_done  in  1  core result valid pulse.
- core_result  in  BLK_BITS  sampled on the cycle core_done=1.

Behaviour:
- Reset (rst=1 at posedge):
  - state <= IDLE; bit counter <= 0.
  - mosi, finished, err, busy, core_start <= 0.
  - core_data, core_key, result register <= 0.
  - Reset has priority over every other event, including mid-transaction.
- States: IDLE, RX_DATA, RX_KEY, START, WAIT, TX, DONE.
- IDLE:
  - cs=1 -> RX_DATA; the miso bit in that same cycle is data bit 0.
- RX_DATA:
  - Each posedge stores miso into core_data[cnt], LSB first.
  - After bit 127 -> RX_KEY with cnt=0.
- RX_KEY:
  - Stores into core_key[cnt], LSB first.
  - After bit KEY_BITS-1 -> START.
- START:
  - core_start=1 for exactly this cycle -> WAIT.
  - core_start rises one cycle after the last key bit is sampled.
- WAIT:
  - core_done is sampled only here; it is ignored in every other state.
  - On core_done: latch core_result, go to TX with cnt=0.
- TX:
  - mosi = result[cnt], registered; bit 0 is driven on the first TX cycle, one bit per cycle.
  - After bit 127 -> DONE.
- DONE:
  - finished=1 (err=0) in the first DONE cycle only; mosi=0.
  - Stays in DONE while cs=1; miso is ignored.
  - cs=0 -> IDLE. A new transaction always requires cs low for at least one cycle.
- Abort:
  - cs=0 in RX_DATA, RX_KEY, START, WAIT or TX -> IDLE next cycle, mosi=0, no finished.
  - If the abort happens in WAIT or after START, a late core_done is ignored.
  - If cs drops in the same cycle as the last RX bit, the abort wins and core_start never pulses.
- Counter: log2(max(BLK_BITS, KEY_BITS)) bits wide; it never wraps within a phase.
- Transaction latency with cs held high: BLK_BITS + KEY_BITS + 1 + core latency + BLK_BITS cycles to finished.

Optional Feature:
- Macro: AES_SER_PARITY_EN.
- Defined:
  - An extra state RX_PAR sits between RX_KEY and START and samples one parity bit.
  - The XOR of all BLK_BITS + KEY_BITS + 1 received bits must be 0 (even parity).
  - Mismatch -> skip START/WAIT/TX and go directly to DONE with finished=1, err=1, mosi=0, no core_start.
- Undefined: no parity bit is expected; err is tied 0.

Decomposition:
- Package aes_ser_pkg holds:
  - the state enum;
  - the BLK_BITS constant;
  - a function key_bits(Nk) = 32*Nk;
  - a counter-width function.
- One sub-module, aes_ser_shreg: parameterized-width indexed bit capture/emit register with bit counter and last-bit flag.
  - Instantiated for data, key and result.

Test Plan:
- FIPS-197 AES-128 (Nk=4): data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f; core model answers 69c4e0d86a7b0430d8cdb78070b4c55a after 5 cycles.
  -> core_data/core_key match; single core_start 1 cycle after bit 255; mosi streams the result LSB first over 128 cycles; one finished pulse, err=0.
- Nk=6: key 000102030405060708090a0b0c0d0e0f1011121314151617, model result dda97ca4864cdfe06eaf70a0ec0d7191.
  -> core_key is 192 bits; core_start 1 cycle after bit 319; mosi reproduces the result exactly.
- cs dropped after data bit 100.
  -> no core_start, busy=0 next cycle; the following full transaction completes correctly.
- rst asserted at TX bit 50.
  -> next cycle mosi=0, finished=0, busy=0; a late core_done is ignored; a fresh transaction succeeds.
- cs held high 20 cycles past finished with random miso.
  -> no second finished or core_start; cs low 1 cycle then high starts a clean RX.
- With AES_SER_PARITY_EN, vector 1 with the parity bit flipped.
  -> finished=1 with err=1, core_start never asserted, mosi stays 0. Correct parity gives the vector-1 result.
